// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package hex_disp_pkg;

  // Which producer currently owns the display.
  typedef enum logic [0:0] {
    SHOW_A = 1'b0,
    OVR    = 1'b1
  } dispState_t;

  // Active-low code that turns every segment of a digit off (incl. DP).
  localparam logic [7:0] BLANK_CODE = 8'hFF;

  localparam int NUM_DIGITS = 8;
  localparam int NIB_W      = 4;

endpackage

// File: rtl/hex_seg_lut.sv
// Hex nibble to active-low seven-segment glyph (bit order gfedcba).
module hex_seg_lut
  import hex_disp_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [6:0]       seg
);

  // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_disp_sched.sv
// Display scheduler for eight seven-segment digits: arbitrates a status
// source (A) and a debug override source (B) with a minimum hold time,
// rate-limits updates to a refresh tick, applies leading-zero blanking and
// decimal points. Optional blinking is compiled in with macro BLINK_EN.
module hex_disp_sched
  import hex_disp_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int HOLD_TICKS  = 2000,
  parameter int BLINK_TICKS = 250
)(
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iA_VALID,
  input  logic [31:0] iA_DATA,
  output logic        oA_READY,
  input  logic        iB_VALID,
  input  logic [31:0] iB_DATA,
  output logic        oB_READY,
  input  logic        iLZ_EN,
  input  logic [7:0]  iDP,
  input  logic [7:0]  iBLINK_MASK,
  output logic        oOVR,
  output logic [63:0] oHEX
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  logic [DIV_W-1:0]  divCnt_r;
  logic              tick_s;
  logic              tickDly_r;
  logic              aReady_r, bReady_r;
  logic              aXfer_s, bXfer_s;
  logic [31:0]       shadowA_r, shadowB_r;
  dispState_t        state_r, stateNext_s;
  logic [HOLD_W-1:0] holdCnt_r, holdNext_s;
  logic [31:0]       dispWord_r, dispNext_s;
  logic              ovr_r;
  logic              lzEn_r;
  logic [7:0]        dp_r, blinkMask_r;
  logic              blinkOn_s;
  logic              higherZero_s;
  logic [6:0]        seg_s [NUM_DIGITS];
  logic [63:0]       hexNext_s, hex_r;

  assign tick_s  = (divCnt_r == DIV_W'(TICK_DIV - 1));
  // A pending (uncommitted) update is the same thing as "not ready".
  assign aXfer_s = iA_VALID & aReady_r;
  assign bXfer_s = iB_VALID & bReady_r;

  // Refresh prescaler: 1-cycle tick every TICK_DIV clocks.
  always_ff @(posedge iCLK) begin
    if (!iRST_N)     divCnt_r <= DIV_W'(0);
    else if (tick_s) divCnt_r <= DIV_W'(0);
    else             divCnt_r <= divCnt_r + DIV_W'(1);
  end

  // Source handshakes: accept into shadow, stay busy until the next tick commits it.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      aReady_r  <= 1'b1;
      bReady_r  <= 1'b1;
      shadowA_r <= 32'h0;
      shadowB_r <= 32'h0;
    end else begin
      if (aXfer_s) begin
        shadowA_r <= iA_DATA;
        aReady_r  <= 1'b0;
      end else if (tick_s) begin
        aReady_r  <= 1'b1;
      end else begin
        aReady_r  <= aReady_r;
      end
      if (bXfer_s) begin
        shadowB_r <= iB_DATA;
        bReady_r  <= 1'b0;
      end else if (tick_s) begin
        bReady_r  <= 1'b1;
      end else begin
        bReady_r  <= bReady_r;
      end
    end
  end

  // Owner selection at each tick; the word loaded is the new owner's shadow.
  always_comb begin
    stateNext_s = state_r;
    holdNext_s  = holdCnt_r;
    dispNext_s  = dispWord_r;
    if (tick_s) begin
      case (state_r)
        SHOW_A: begin
          if (!bReady_r) begin
            stateNext_s = OVR;
            holdNext_s  = HOLD_W'(HOLD_TICKS);
            dispNext_s  = shadowB_r;
          end else begin
            dispNext_s  = shadowA_r;
          end
        end
        OVR: begin
          if (!bReady_r) begin
            holdNext_s  = HOLD_W'(HOLD_TICKS);
            dispNext_s  = shadowB_r;
          end else if (holdCnt_r == HOLD_W'(1)) begin
            stateNext_s = SHOW_A;
            holdNext_s  = HOLD_W'(0);
            dispNext_s  = shadowA_r;
          end else begin
            holdNext_s  = holdCnt_r - HOLD_W'(1);
            dispNext_s  = shadowB_r;
          end
        end
        default: begin
          stateNext_s = SHOW_A;
          holdNext_s  = HOLD_W'(0);
          dispNext_s  = shadowA_r;
        end
      endcase
    end else begin
      stateNext_s = state_r;
      holdNext_s  = holdCnt_r;
      dispNext_s  = dispWord_r;
    end
  end

  // FSM state, display word and the per-tick sampled display options.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_r     <= SHOW_A;
      holdCnt_r   <= HOLD_W'(0);
      dispWord_r  <= 32'h0;
      ovr_r       <= 1'b0;
      lzEn_r      <= 1'b0;
      dp_r        <= 8'h00;
      blinkMask_r <= 8'h00;
    end else begin
      state_r    <= stateNext_s;
      holdCnt_r  <= holdNext_s;
      dispWord_r <= dispNext_s;
      ovr_r      <= (stateNext_s == OVR);
      if (tick_s) begin
        lzEn_r      <= iLZ_EN;
        dp_r        <= iDP;
        blinkMask_r <= iBLINK_MASK;
      end else begin
        lzEn_r      <= lzEn_r;
        dp_r        <= dp_r;
        blinkMask_r <= blinkMask_r;
      end
    end
  end

`ifdef BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
  logic [BLINK_W-1:0] blinkCnt_r;
  logic               blinkPhase_r;

  // Blink phase flips every BLINK_TICKS ticks, starting visible.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      blinkCnt_r   <= BLINK_W'(0);
      blinkPhase_r <= 1'b1;
    end else if (tick_s) begin
      if (blinkCnt_r == BLINK_W'(BLINK_TICKS - 1)) begin
        blinkCnt_r   <= BLINK_W'(0);
        blinkPhase_r <= ~blinkPhase_r;
      end else begin
        blinkCnt_r   <= blinkCnt_r + BLINK_W'(1);
      end
    end else begin
      blinkCnt_r   <= blinkCnt_r;
      blinkPhase_r <= blinkPhase_r;
    end
  end

  assign blinkOn_s = blinkPhase_r;
`else
  // Without blinking the mask register never gates anything.
  assign blinkOn_s = 1'b1;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gLut
    hex_seg_lut uLut (
      .nib (dispWord_r[g*NIB_W +: NIB_W]),
      .seg (seg_s[g])
    );
  end

  // Per-digit composition: leading-zero blank, blink blank, or DP + glyph.
  always_comb begin
    higherZero_s = 1'b1;
    hexNext_s    = {64{1'b1}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higherZero_s = higherZero_s & (dispWord_r[k*NIB_W +: NIB_W] == 4'h0);
      if ((lzEn_r & higherZero_s & (k != 0)) | (~blinkOn_s & blinkMask_r[k])) begin
        hexNext_s[k*8 +: 8] = BLANK_CODE;
      end else begin
        hexNext_s[k*8 +: 8] = {~dp_r[k], seg_s[k]};
      end
    end
  end

  // Output register only loads in the cycle after a tick, so the pins stay
  // dark from reset until the first committed word.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      tickDly_r <= 1'b0;
      hex_r     <= {64{1'b1}};
    end else begin
      tickDly_r <= tick_s;
      if (tickDly_r) hex_r <= hexNext_s;
      else           hex_r <= hex_r;
    end
  end

  assign oA_READY = aReady_r;
  assign oB_READY = bReady_r;
  assign oOVR     = ovr_r;
  assign oHEX     = hex_r;

endmodule

// File: tb/tb_hex_disp_sched.sv
// Self-checking bench for hex_disp_sched: directed scenarios plus random
// traffic, every cycle compared against a tick-level behavioural model.
module tb_hex_disp_sched;

  localparam int TICK_DIV    = 4;
  localparam int HOLD_TICKS  = 3;
  localparam int BLINK_TICKS = 2;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iA_VALID = 1'b0, iB_VALID = 1'b0;
  logic [31:0] iA_DATA = 32'h0, iB_DATA = 32'h0;
  logic        oA_READY, oB_READY, oOVR;
  logic        iLZ_EN = 1'b0;
  logic [7:0]  iDP = 8'h00, iBLINK_MASK = 8'h00;
  logic [63:0] oHEX;

  always #5 iCLK = ~iCLK;

  hex_disp_sched #(.TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS), .BLINK_TICKS(BLINK_TICKS)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iA_VALID(iA_VALID), .iA_DATA(iA_DATA), .oA_READY(oA_READY),
    .iB_VALID(iB_VALID), .iB_DATA(iB_DATA), .oB_READY(oB_READY),
    .iLZ_EN(iLZ_EN), .iDP(iDP), .iBLINK_MASK(iBLINK_MASK),
    .oOVR(oOVR), .oHEX(oHEX)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state (tick-level view)
  int          mCyc, mTicks, mLastB;
  bit          mPendA, mPendB, mOvr, mTickPrev, mXferA, mXferB, mLz;
  logic [31:0] mShA, mShB, mWord;
  logic [7:0]  mDp, mMask;
  logic [63:0] mHex;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit phaseOn(input int t);
`ifdef BLINK_EN
    return ((t / BLINK_TICKS) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] render(input logic [31:0] w, input bit lz,
                                         input logic [7:0] dp, input logic [7:0] mask, input bit on);
    logic [63:0] r;
    logic [31:0] hi;
    r = '1;
    for (int k = 0; k < 8; k++) begin
      hi = w >> (4 * k);
      if ((lz && k > 0 && hi == 32'h0) || (!on && mask[k])) r[8*k +: 8] = 8'hFF;
      else r[8*k +: 8] = {~dp[k], glyph[hi[3:0]]};
    end
    return r;
  endfunction

  task automatic modelStep();
    bit tick, xa, xb;
    if (!iRST_N) begin
      mCyc = 0; mTicks = 0; mLastB = -1000;
      mPendA = 0; mPendB = 0; mOvr = 0; mTickPrev = 0; mXferA = 0; mXferB = 0;
      mShA = 32'h0; mShB = 32'h0; mWord = 32'h0; mLz = 0; mDp = 8'h0; mMask = 8'h0;
      mHex = '1;
      return;
    end
    tick = (mCyc % TICK_DIV) == TICK_DIV - 1;
    xa = iA_VALID && !mPendA;
    xb = iB_VALID && !mPendB;
    if (mTickPrev) mHex = render(mWord, mLz, mDp, mMask, phaseOn(mTicks));
    if (tick) begin
      mTicks++;
      if (mPendB) mLastB = mTicks;
      mOvr  = (mTicks - mLastB) < HOLD_TICKS;
      mWord = mOvr ? mShB : mShA;
      mLz = iLZ_EN; mDp = iDP; mMask = iBLINK_MASK;
    end
    if (xa) begin mShA = iA_DATA; mPendA = 1; end else if (tick) mPendA = 0;
    if (xb) begin mShB = iB_DATA; mPendB = 1; end else if (tick) mPendB = 0;
    mXferA = xa; mXferB = xb;
    mTickPrev = tick;
    mCyc++;
  endtask

  task automatic cyc();
    @(posedge iCLK);
    modelStep();
    #1;
    checkVal("hex", oHEX, mHex);
    checkVal("ovr", 64'(oOVR), 64'(mOvr));
    checkVal("aReady", 64'(oA_READY), 64'(!mPendA));
    checkVal("bReady", 64'(oB_READY), 64'(!mPendB));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic sendA(input logic [31:0] d);
    bit done = 0;
    int n = 0;
    iA_VALID = 1'b1; iA_DATA = d;
    while (!done && n < 3 * TICK_DIV) begin
      done = oA_READY;
      cyc();
      n++;
    end
    iA_VALID = 1'b0;
    checkVal("aXferTimeout", 64'(done), 64'd1);
  endtask

  task automatic sendB(input logic [31:0] d);
    bit done = 0;
    int n = 0;
    iB_VALID = 1'b1; iB_DATA = d;
    while (!done && n < 3 * TICK_DIV) begin
      done = oB_READY;
      cyc();
      n++;
    end
    iB_VALID = 1'b0;
    checkVal("bXferTimeout", 64'(done), 64'd1);
  endtask

  initial begin
    bit ra, rb;
    // reset
    iRST_N = 1'b0;
    run(2);
    checkVal("rstHex", oHEX, {64{1'b1}});
    checkVal("rstOvr", 64'(oOVR), 64'd0);
    iRST_N = 1'b1;
    iLZ_EN = 1'b1; iDP = 8'h00;

    // first value with leading-zero blanking
    sendA(32'h0000_12AF);
    run(8);
    checkVal("lzValue", oHEX, 64'hFFFF_FFFF_F9A4_888E);

    // back-to-back A values
    sendA(32'h0000_0345);
    sendA(32'h0000_0678);
    run(10);
    checkVal("backToBack", oHEX, 64'hFFFF_FFFF_FF82_F880);

    // override from B, A update hidden until the hold expires
    sendB(32'hDEAD_BEEF);
    run(6);
    checkVal("ovrOn", 64'(oOVR), 64'd1);
    checkVal("ovrHex", oHEX, 64'hA186_88A1_8386_868E);
    sendA(32'h0000_0009);
    run(2);
    checkVal("ovrHidesA", oHEX, 64'hA186_88A1_8386_868E);
    run(16);
    checkVal("ovrOff", 64'(oOVR), 64'd0);
    checkVal("aReturns", oHEX, 64'hFFFF_FFFF_FFFF_FF90);

    // A and B in the same cycle
    iA_VALID = 1'b1; iA_DATA = 32'h0000_ABCD;
    iB_VALID = 1'b1; iB_DATA = 32'h1234_5678;
    ra = oA_READY; rb = oB_READY;
    cyc();
    iA_VALID = 1'b0; iB_VALID = 1'b0;
    checkVal("bothAccepted", {62'd0, ra, rb}, 64'd3);
    run(6);
    checkVal("bothBWins", oHEX, 64'hF9A4_B099_9282_F880);
    run(16);
    checkVal("bothAAfter", oHEX, 64'hFFFF_FFFF_8883_C6A1);

    // reset in the middle of an override
    sendB(32'h00C0_FFEE);
    run(6);
    checkVal("preRstOvr", 64'(oOVR), 64'd1);
    iRST_N = 1'b0;
    cyc();
    iRST_N = 1'b1;
    checkVal("midRstHex", oHEX, {64{1'b1}});
    checkVal("midRstOvr", 64'(oOVR), 64'd0);
    checkVal("midRstReady", {62'd0, oA_READY, oB_READY}, 64'd3);

    // blink on digit 0 (steady when blinking is not built in)
    iLZ_EN = 1'b1; iBLINK_MASK = 8'h01;
    sendA(32'h0000_0005);
    run(40);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!iA_VALID || mXferA) begin
        iA_VALID = ($urandom_range(0, 3) == 0);
        iA_DATA  = $urandom >> (4 * $urandom_range(0, 8));
      end
      if (!iB_VALID || mXferB) begin
        iB_VALID = ($urandom_range(0, 19) == 0);
        iB_DATA  = $urandom >> (4 * $urandom_range(0, 8));
      end
      if ($urandom_range(0, 15) == 0) iLZ_EN = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) iDP = 8'($urandom);
      if ($urandom_range(0, 15) == 0) iBLINK_MASK = 8'($urandom);
      iRST_N = ($urandom_range(0, 799) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_disp_sched.md
Name: hex_disp_sched

Overview:
- Display scheduler for the eight DE2-70 seven-segment digits.
- Arbitrates two producers of a 32-bit hex value:
  - A: normal system status.
  - B: debug override with minimum hold time.
- Rate-limits updates to a refresh tick and applies leading-zero blanking and decimal points.
- Drives 8 active-low digit encodings through eight instances of a hex-to-segment LUT sub-module.
- Sits between the system/debug logic and the board HEX pins.

Parameters:
TICK_DIV, 50000, iCLK cycles per refresh tick (>=2)
HOLD_TICKS, 2000, ticks an override from B stays on display after its last update (>=1)
BLINK_TICKS, 250, ticks per blink half-period (only with BLINK_EN)

Ports:
iCLK  in  1  system clock
iRST_N  in  1  synchronous active-low reset
iA_VALID  in  1  source A data valid
iA_DATA  in  32  source A value, nibble k -> digit k
oA_READY  out  1  source A may transfer
iB_VALID  in  1  source B (override) data valid
iB_DATA  in  32  source B value
oB_READY  out  1  source B may transfer
iLZ_EN  in  1  suppress leading zero digits
iDP  in  8  decimal point per digit, active-high
iBLINK_MASK  in  8  digits to blink (ignored without BLINK_EN)
oOVR  out  1  override (B) currently displayed
oHEX  out  64  digit k on [8k+7:8k], active-low hgfedcba

Behaviour:
- Clock and reset: single clock iCLK. Reset iRST_N is synchronous, active-low, sampled on iCLK rising edge; everything is cleared on that edge, including mid-hold.
- Reset values:
  - oHEX = all ones (all segments off).
  - oA_READY = 1, oB_READY = 1, oOVR = 0.
  - FSM = SHOW_A; shadows = 0; pend flags = 0; counters = 0.
- Tick:
  - Prescaler counts 0..TICK_DIV-1; tick is a 1-cycle pulse when the count = TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after reset release.
- Handshakes:
  - Transfer = VALID & READY. oX_READY = ~pendX.
  - A transfer loads shadowX <= DATA and sets pendX.
  - pendX clears on the next tick (commit). Max one accepted update per source per tick.
  - A source holding VALID with no transfer must hold DATA stable.
- FSM:
  - SHOW_A: displayed value = shadowA. Tick with pendB -> OVR, hold_cnt <= HOLD_TICKS, oOVR <= 1.
  - OVR: displayed value = shadowB.
    - Tick with pendB -> hold_cnt reloads to HOLD_TICKS.
    - Otherwise tick decrements hold_cnt; tick at hold_cnt = 1 -> SHOW_A, oOVR <= 0.
  - Source A continues to be accepted in OVR and becomes visible on return.
- Simultaneous events:
  - A and B commit on the same tick: B wins the display; A's shadow is still updated.
  - Acceptance and commit in the same cycle: the commit sees the old pend. The new data commits on the following tick.
- Output pipeline:
  - Display word is registered at the tick. oHEX is registered one cycle later (latency from commit tick to oHEX = 1 cycle).
  - oHEX changes only in the cycle after a tick.
- Leading-zero blanking (iLZ_EN = 1):
  - Digits 7 down to 1 are blanked (8'hFF) while they and all higher digits are 0.
  - Digit 0 is never blanked.
  - A blanked digit also blanks its DP.
- DP:
  - Segment h = ~iDP[k], merged with the LUT output (LUT supplies bits 6:0).
  - iLZ_EN and iDP are sampled at the tick.

Optional Feature:
- Macro BLINK_EN.
- Defined:
  - A blink counter counts ticks; the blink phase toggles every BLINK_TICKS ticks.
  - Phase resets to on (visible).
  - During the off phase, digits with iBLINK_MASK[k] = 1 output 8'hFF.
  - iBLINK_MASK is sampled at the tick.
- Undefined: no blink counter; iBLINK_MASK is ignored; the port remains for a stable pinout.

Decomposition:
- Package hex_disp_pkg:
  - FSM state enum (SHOW_A, OVR).
  - Blank code 8'hFF.
  - Digit count 8, nibble width 4.
- Sub-module hex_seg_lut:
  - Combinational 4-bit -> 7-bit active-low segment code.
  - 0..F as standard hex glyphs (0 = 7'h40, F = 7'h0E).
  - Instanced 8 times.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2):
- Reset, A sends 32'h0000_12AF, iLZ_EN=1, iDP=0:
  - oHEX = all ones until the cycle after the first tick.
  - Then digits 0..3 = F,A,2,1 (8'h8E,8'h88,8'hA4,8'hF9); digits 4..7 = 8'hFF.
- A holds VALID with 2 values back-to-back:
  - oA_READY drops 1 cycle after the first transfer and rises after the tick.
  - The second value displays exactly one tick later.
- B sends 32'hDEAD_BEEF while showing A:
  - oOVR = 1 after the tick.
  - B is held for 3 ticks with no B traffic, then A's latest value returns and oOVR = 0.
  - A updates during OVR are not displayed until the return.
- A and B valid in the same cycle:
  - B displayed.
  - After the hold expires, A's value from that cycle is shown.
- Assert iRST_N=0 for 1 cycle mid-override:
  - Next cycle oHEX = all ones, oOVR = 0, both READY = 1.
- BLINK_EN, iBLINK_MASK=8'h01, value 8'h5:
  - Digit 0 alternates 8'h92 / 8'hFF every 2 ticks.
  - Other digits are steady.
